multicycle_control: RTL and testbench

Multi-cycle sequencing controller for the MIPS-subset datapath: shared instruction/data memory, one ALU, ALUOut/MDR/IR registers. It walks each instruction through fetch, decode, execute, memory and writeback states and drives the datapath select/enable lines per state. It handles the memory ready handshake with a timeout. It replaces single-cycle opcode decoding for the opcode set R-type(4), addiu(12), subiu(13), sw(16) and lw(17).

---
 rtl/multicycle_control.sv | 162 ++++++++++++++++
 tb/tb_multicycle_control.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle sequencing controller for the MIPS-subset datapath.
// Walks each instruction through IF/ID/EX/MEM/WB and drives the datapath selects and enables.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OpCode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       InstrDone,
  output logic       Illegal,
  output logic       BusError,
  output logic [3:0] State
);

  localparam int CW = $clog2(MEM_TIMEOUT) + 1;

  localparam logic [5:0] OP_RTYPE = 6'd4;
  localparam logic [5:0] OP_ADDIU = 6'd12;
  localparam logic [5:0] OP_SUBIU = 6'd13;
  localparam logic [5:0] OP_SW    = 6'd16;
  localparam logic [5:0] OP_LW    = 6'd17;

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EX_R   = 4'd2,
    S_EX_I   = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_R   = 4'd7,
    S_WB_I   = 4'd8,
    S_WB_MEM = 4'd9
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [5:0]      r_op;
  logic [CW-1:0]   r_wait;
  logic            w_wait_state;
  logic            w_timeout;

  // IF, MEM_RD and MEM_WR are the only states that wait on the memory handshake.
  assign w_wait_state = (r_state == S_IF) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  assign w_timeout    = w_wait_state && !mem_ready && (r_wait == CW'(MEM_TIMEOUT - 1));
  assign State        = r_state;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IF;
      r_op    <= '0;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_ID) r_op <= OpCode;
      // The counter is zero in every non-waiting state, so entering a wait state starts it cleared.
      if (w_wait_state && !mem_ready && !w_timeout) r_wait <= r_wait + 1'b1;
      else                                          r_wait <= '0;
    end
  end

  // NOTE: every output and w_next gets a default before the case, so no path can infer a latch.
  always_comb begin
    w_next    = S_IF;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    MemtoReg  = 1'b0;
    RegDst    = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b01;
    InstrDone = 1'b0;
    Illegal   = 1'b0;
    BusError  = 1'b0;
    unique case (r_state)
      S_IF: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (mem_ready) begin
          // Mealy strobes are held off while reset is asserted.
          IRWrite = !rst;
          PCWrite = !rst;
          w_next  = S_ID;
        end else if (w_timeout) begin
          BusError = 1'b1;
        end
      end
      S_ID: begin
        unique case (OpCode)
          OP_RTYPE:          w_next = S_EX_R;
          OP_ADDIU, OP_SUBIU: w_next = S_EX_I;
          OP_SW, OP_LW:      w_next = S_ADDR;
          default:           Illegal = 1'b1;
        endcase
      end
      S_EX_R: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b00;
        ALUOp   = 2'b10;
        w_next  = S_WB_R;
      end
      S_WB_R: begin
        RegWrite  = 1'b1;
        RegDst    = 1'b1;
        InstrDone = 1'b1;
      end
      S_EX_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = (r_op == OP_SUBIU) ? 2'b00 : 2'b01;
        w_next  = S_WB_I;
      end
      S_WB_I: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
      end
      S_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = (r_op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (mem_ready)      w_next = S_WB_MEM;
        else if (w_timeout) BusError = 1'b1;
        else                w_next = S_MEM_RD;
      end
      S_MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready)      InstrDone = 1'b1;
        else if (w_timeout) BusError = 1'b1;
        else                w_next = S_MEM_WR;
      end
      S_WB_MEM: begin
        RegWrite  = 1'b1;
        MemtoReg  = 1'b1;
        InstrDone = 1'b1;
      end
      default: w_next = S_IF;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle expected output vectors are queued
// with their stimulus and compared against the DUT each cycle.
module tb_multicycle_control;

  localparam int T = 16;

  logic       clk, rst;
  logic [5:0] OpCode;
  logic       mem_ready;
  logic       PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp;
  logic       InstrDone, Illegal, BusError;
  logic [3:0] State;

  multicycle_control #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .OpCode(OpCode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .InstrDone(InstrDone),
    .Illegal(Illegal), .BusError(BusError), .State(State)
  );

  typedef struct packed {
    logic [3:0] st;
    logic pcw, irw, iord, mrd, mwr, m2r, rdst, rw, srca;
    logic [1:0] srcb, aluop;
    logic done, ill, berr;
  } outv_t;

  typedef struct {
    bit         rdy;
    logic [5:0] op;
    outv_t      exp;
    string      tag;
  } item_t;

  item_t q[$];
  outv_t obs;
  int    n_checks = 0;
  int    n_fail   = 0;

  assign obs = {State, PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegDst, RegWrite,
                ALUSrcA, ALUSrcB, ALUOp, InstrDone, Illegal, BusError};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic outv_t base(input logic [3:0] st);
    outv_t v = '0;
    v.st    = st;
    v.aluop = 2'b01;
    return v;
  endfunction

  function automatic outv_t e_if(input bit rdy, input bit to);
    outv_t v = base(4'd0);
    v.mrd = 1'b1; v.srcb = 2'b01; v.pcw = rdy; v.irw = rdy; v.berr = to;
    return v;
  endfunction

  function automatic outv_t e_id(input bit ill);
    outv_t v = base(4'd1);
    v.ill = ill;
    return v;
  endfunction

  function automatic outv_t e_ex_r();
    outv_t v = base(4'd2);
    v.srca = 1'b1; v.srcb = 2'b00; v.aluop = 2'b10;
    return v;
  endfunction

  function automatic outv_t e_ex_i(input bit sub);
    outv_t v = base(4'd3);
    v.srca = 1'b1; v.srcb = 2'b10; v.aluop = sub ? 2'b00 : 2'b01;
    return v;
  endfunction

  function automatic outv_t e_addr();
    outv_t v = base(4'd4);
    v.srca = 1'b1; v.srcb = 2'b10;
    return v;
  endfunction

  function automatic outv_t e_mem_rd(input bit to);
    outv_t v = base(4'd5);
    v.iord = 1'b1; v.mrd = 1'b1; v.berr = to;
    return v;
  endfunction

  function automatic outv_t e_mem_wr(input bit rdy, input bit to);
    outv_t v = base(4'd6);
    v.iord = 1'b1; v.mwr = 1'b1; v.done = rdy; v.berr = to;
    return v;
  endfunction

  function automatic outv_t e_wb(input logic [3:0] st);
    outv_t v = base(st);
    v.rw   = 1'b1;
    v.done = 1'b1;
    v.rdst = (st == 4'd7);
    v.m2r  = (st == 4'd9);
    return v;
  endfunction

  function automatic bit dc(input bit hold);
    return hold ? 1'b1 : 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input bit rdy, input logic [5:0] op, input outv_t e, input string tag);
    item_t it;
    it.rdy = rdy; it.op = op; it.exp = e; it.tag = tag;
    q.push_back(it);
  endtask

  // Queue one instruction; if_wait/mem_wait are not-ready cycles before mem_ready (>= T means timeout).
  task automatic gen_instr(input logic [5:0] op, input int if_wait, input int mem_wait,
                           input logic [5:0] junk, input bit hold);
    string t = $sformatf("op%0d", op);
    int    n;
    for (int i = 0; i < if_wait; i++) push(1'b0, junk, e_if(1'b0, (i % T) == T - 1), {t, " IF wait"});
    push(1'b1, junk, e_if(1'b1, 1'b0), {t, " IF"});
    n = (mem_wait < T) ? mem_wait : T;
    case (op)
      6'd4: begin
        push(dc(hold), op, e_id(1'b0), {t, " ID"});
        push(dc(hold), junk, e_ex_r(), {t, " EX_R"});
        push(dc(hold), junk, e_wb(4'd7), {t, " WB_R"});
      end
      6'd12, 6'd13: begin
        push(dc(hold), op, e_id(1'b0), {t, " ID"});
        push(dc(hold), junk, e_ex_i(op == 6'd13), {t, " EX_I"});
        push(dc(hold), junk, e_wb(4'd8), {t, " WB_I"});
      end
      6'd16, 6'd17: begin
        push(dc(hold), op, e_id(1'b0), {t, " ID"});
        push(dc(hold), junk, e_addr(), {t, " ADDR"});
        for (int i = 0; i < n; i++) begin
          if (op == 6'd17) push(1'b0, junk, e_mem_rd(i == T - 1), {t, " MEM_RD wait"});
          else             push(1'b0, junk, e_mem_wr(1'b0, i == T - 1), {t, " MEM_WR wait"});
        end
        if (mem_wait < T) begin
          if (op == 6'd17) begin
            push(1'b1, junk, e_mem_rd(1'b0), {t, " MEM_RD"});
            push(dc(hold), junk, e_wb(4'd9), {t, " WB_MEM"});
          end else begin
            push(1'b1, junk, e_mem_wr(1'b1, 1'b0), {t, " MEM_WR"});
          end
        end
      end
      default: push(dc(hold), op, e_id(1'b1), {t, " ID illegal"});
    endcase
  endtask

  // Entered #1 after a rising edge; drives each cycle's inputs and compares at the falling edge.
  task automatic run();
    item_t it;
    while (q.size() > 0) begin
      it        = q.pop_front();
      mem_ready = it.rdy;
      OpCode    = it.op;
      @(negedge clk);
      check(it.tag, 32'(obs), 32'(it.exp));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [5:0] ops [7];
    ops = '{6'd4, 6'd12, 6'd13, 6'd16, 6'd17, 6'd63, 6'd0};
    rst = 1'b1; mem_ready = 1'b1; OpCode = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", 32'(obs), 32'(e_if(1'b0, 1'b0)));
    rst = 1'b0;

    gen_instr(6'd4,  0, 0,  6'd4, 1'b1);
    gen_instr(6'd13, 0, 0,  6'd4, 1'b0);
    gen_instr(6'd12, 0, 0,  6'd13, 1'b0);
    gen_instr(6'd17, 0, 3,  6'd16, 1'b0);
    gen_instr(6'd16, 0, 16, 6'd17, 1'b0);
    gen_instr(6'd63, 0, 0,  6'd4, 1'b0);
    gen_instr(6'd4,  1, 0,  6'd12, 1'b0);
    gen_instr(6'd12, 0, 0,  6'd4, 1'b0);
    gen_instr(6'd17, 0, 15, 6'd4, 1'b0);
    gen_instr(6'd17, 2, 16, 6'd16, 1'b0);
    gen_instr(6'd16, 16, 2, 6'd17, 1'b0);
    gen_instr(6'd16, 0, 15, 6'd13, 1'b0);
    for (int k = 0; k < 8; k++)
      gen_instr(ops[$urandom_range(0, 6)], $urandom_range(0, 2), $urandom_range(0, 4),
                6'($urandom), 1'b0);
    run();

    push(1'b1, 6'd0,  e_if(1'b1, 1'b0), "rstwr IF");
    push(1'b0, 6'd16, e_id(1'b0), "rstwr ID");
    push(1'b0, 6'd4,  e_addr(), "rstwr ADDR");
    for (int i = 0; i < 3; i++) push(1'b0, 6'd4, e_mem_wr(1'b0, 1'b0), "rstwr MEM_WR wait");
    run();
    mem_ready = 1'b0;
    #1;
    check("pre-rst MemWrite", 32'(MemWrite), 32'd1);
    rst = 1'b1;
    #1;
    check("async rst State", 32'(State), 32'd0);
    check("async rst MemWrite", 32'(MemWrite), 32'd0);
    mem_ready = 1'b1;
    #1;
    check("rst held outputs", 32'(obs), 32'(e_if(1'b0, 1'b0)));
    @(posedge clk);
    #1;
    check("rst across edge", 32'(obs), 32'(e_if(1'b0, 1'b0)));
    rst = 1'b0;
    gen_instr(6'd4,  0, 0, 6'd16, 1'b0);
    gen_instr(6'd17, 0, 1, 6'd12, 1'b0);
    run();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
